// File: rtl/pdm_pkg.sv
// Shared constants, types and the PCM-to-offset-binary helper for the PDM transmitter.
package pdm_pkg;

  localparam int PDM_DATA_W = 16;
  localparam int PDM_OSR_W  = 8;
  localparam int PDM_MAX_W  = 32;

  localparam logic [PDM_DATA_W-1:0] PDM_MIDSCALE = {1'b1, {(PDM_DATA_W-1){1'b0}}};

  typedef logic [PDM_OSR_W-1:0] osr_t;

  typedef struct packed {
    logic s1;
    logic s2;
    logic dly;
  } mic_sync_t;

  // Adding 2^(width-1) to a two's-complement value is the same as inverting its MSB.
  function automatic logic [PDM_MAX_W-1:0] to_offset_bin(input logic [PDM_MAX_W-1:0] sample,
                                                         input int unsigned width);
    logic [PDM_MAX_W-1:0] flip;
    flip = {{(PDM_MAX_W-1){1'b0}}, 1'b1} << (width - 32'd1);
    return sample ^ flip;
  endfunction

endpackage

// File: rtl/pdm_tx_fifo.sv
// Small synchronous FIFO with occupancy count; pushes when full and pops when empty are dropped.
module pdm_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == (AW+1)'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// PDM microphone emulator: buffered PCM samples drive a first-order sigma-delta modulator
// that advances on the selected edge of the receiver-supplied microphone clock.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int DATA_W     = PDM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_W-1:0]      sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [PDM_OSR_W-1:0]          osr,
  input  logic                          mic_clk,
  input  logic                          channel,
  output logic                          pdm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt
);

  localparam logic [DATA_W-1:0] MID_U =
    (DATA_W == PDM_DATA_W) ? PDM_MIDSCALE : {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  mic_sync_t         sync_r;
  logic              rise_s;
  logic              fall_s;
  logic              event_s;
  logic              reload_s;
  logic              pop_s;
  logic              push_s;
  logic              underrun_hit_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_rd_data_s;
  logic [DATA_W-1:0] next_u_s;
  logic [DATA_W:0]   sum_s;

  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] cur_u_r;
  osr_t              cur_osr_r;
  osr_t              bit_cnt_r;
  logic              init_r;
  logic              pdm_r;
  logic              underrun_r;
  logic [15:0]       underrun_cnt_r;

  assign push_s       = sample_valid & ~fifo_full_s;
  assign sample_ready = ~fifo_full_s;
  assign next_u_s     = DATA_W'(to_offset_bin(PDM_MAX_W'(fifo_rd_data_s), DATA_W));
  assign sum_s        = {1'b0, acc_r} + {1'b0, cur_u_r};

  assign pdm_out      = pdm_r;
  assign underrun     = underrun_r;
  assign underrun_cnt = underrun_cnt_r;

  pdm_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (sample_in),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  // Two-flop synchronizer for mic_clk plus a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 3'b000;
    end else begin
      sync_r.s1  <= mic_clk;
      sync_r.s2  <= sync_r.s1;
      sync_r.dly <= sync_r.s2;
    end
  end

  // Edge selection by channel and reload decision; the very first event after reset
  // always reloads but is never reported as an underrun.
  always_comb begin
    rise_s = sync_r.s2 & ~sync_r.dly;
    fall_s = ~sync_r.s2 & sync_r.dly;
    if (channel) begin
      event_s = rise_s;
    end else begin
      event_s = fall_s;
    end
    if (event_s && (init_r || (bit_cnt_r == cur_osr_r))) begin
      reload_s = 1'b1;
    end else begin
      reload_s = 1'b0;
    end
    pop_s          = reload_s & ~fifo_empty_s;
    underrun_hit_s = reload_s & fifo_empty_s & ~init_r;
  end

  // Modulator accumulator, output bit, bit counter and per-sample reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {DATA_W{1'b0}};
      cur_u_r   <= MID_U;
      cur_osr_r <= osr;
      bit_cnt_r <= {PDM_OSR_W{1'b0}};
      pdm_r     <= 1'b0;
      init_r    <= 1'b1;
    end else if (event_s) begin
      acc_r <= sum_s[DATA_W-1:0];
      pdm_r <= sum_s[DATA_W];
      if (reload_s) begin
        bit_cnt_r <= {PDM_OSR_W{1'b0}};
        cur_osr_r <= osr;
        init_r    <= 1'b0;
        if (pop_s) begin
          cur_u_r <= next_u_s;
        end
      end else begin
        bit_cnt_r <= bit_cnt_r + PDM_OSR_W'(1);
      end
    end
  end

  // Underrun pulse and saturating underrun counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_r     <= 1'b0;
      underrun_cnt_r <= 16'd0;
    end else begin
      underrun_r <= underrun_hit_s;
      if (underrun_hit_s && (underrun_cnt_r != CNT_MAX)) begin
        underrun_cnt_r <= underrun_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: behavioural modulator model with a scoreboard queue,
// a table of density vectors and hand-written reset/fill/underrun sequences.
module tb_pdm_tx;

  localparam int HALF = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = 16'sd0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic [7:0]         osr = 8'd0;
  logic               mic_clk = 1'b0;
  logic               channel = 1'b1;
  logic               pdm_out;
  logic [2:0]         fifo_level;
  logic               underrun;
  logic [15:0]        underrun_cnt;

  always #10 clk = ~clk;

  pdm_tx #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .osr          (osr),
    .mic_clk      (mic_clk),
    .channel      (channel),
    .pdm_out      (pdm_out),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_acc, m_u, m_osr, m_cnt, m_urc;
  bit m_init, m_pdm;
  int m_fifo[$];
  int bits_q[$];

  typedef struct { bit pdm; bit ur; int level; int cnt; } exp_t;
  exp_t sb[$];

  typedef struct { int sample; int osr; int exp_ones; } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0; m_u = 32768; m_osr = 0; m_cnt = 0; m_urc = 0;
    m_init = 1'b1; m_pdm = 1'b0;
    m_fifo.delete();
    sb.delete();
  endfunction

  function automatic void model_event(output exp_t e);
    int sum;
    bit reload;
    sum    = m_acc + m_u;
    m_pdm  = (sum >= 65536);
    m_acc  = sum % 65536;
    reload = m_init || (m_cnt == m_osr);
    e.ur   = 1'b0;
    if (reload) begin
      m_cnt = 0;
      m_osr = int'(osr);
      if (m_fifo.size() > 0) begin
        m_u = m_fifo.pop_front() + 32768;
      end else if (!m_init) begin
        e.ur = 1'b1;
        if (m_urc < 65535) m_urc++;
      end
      m_init = 1'b0;
    end else begin
      m_cnt++;
    end
    e.pdm   = m_pdm;
    e.level = m_fifo.size();
    e.cnt   = m_urc;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; mic_clk = 1'b0;
    @(posedge clk); #1;
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pdm", 32'(pdm_out), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push(input int s);
    @(negedge clk);
    sample_in = 16'(s); sample_valid = 1'b1;
    m_fifo.push_back(s);
    @(negedge clk);
    sample_valid = 1'b0;
    check("push_level", 32'(fifo_level), 32'(m_fifo.size()));
  endtask

  // One mic_clk transition; checks the 3-clk latency of the output update.
  task automatic mic_toggle(output bit was_event);
    bit   lvl, ev, prev;
    exp_t e;
    lvl  = ~mic_clk;
    ev   = channel ? lvl : ~lvl;
    prev = m_pdm;
    @(negedge clk);
    mic_clk = lvl;
    if (ev) begin
      model_event(e);
      sb.push_back(e);
    end
    @(posedge clk); @(posedge clk); #1;
    check("pdm_early", 32'(pdm_out), 32'(prev));
    @(posedge clk); #1;
    if (ev) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pdm_bit", 32'(pdm_out), 32'(e.pdm));
        check("underrun_pulse", 32'(underrun), 32'(e.ur));
        check("event_level", 32'(fifo_level), 32'(e.level));
        check("event_underrun_cnt", 32'(underrun_cnt), 32'(e.cnt));
      end
    end else begin
      check("pdm_nonevent", 32'(pdm_out), 32'(prev));
      check("underrun_nonevent", 32'(underrun), 32'd0);
    end
    @(posedge clk); #1;
    check("underrun_width", 32'(underrun), 32'd0);
    repeat (HALF - 4) @(posedge clk);
    was_event = ev;
  endtask

  task automatic run_events(input int n, output int ones);
    int got;
    bit ev;
    got  = 0;
    ones = 0;
    bits_q.delete();
    while (got < n) begin
      mic_toggle(ev);
      if (ev) begin
        got++;
        ones += int'(pdm_out);
        bits_q.push_back(int'(pdm_out));
      end
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    // Sample counts chosen so N*u is a multiple of 2^16 (ones count independent of acc),
    // except the first, which starts from the known post-reset acc of 32768.
    tbl[0] = '{0,       0,  1};
    tbl[1] = '{16384,   3,  3};
    tbl[2] = '{-32768,  63, 0};
    tbl[3] = '{0,       7,  4};
    tbl[4] = '{-16384,  3,  1};
    tbl[5] = '{8192,    15, 10};
    tbl[6] = '{-24576,  7,  1};

    model_reset();
    do_reset();

    // Silence with no samples: alternating bits, underrun on every reload but the first.
    channel = 1'b1; osr = 8'd3;
    run_events(12, ones);
    for (int i = 0; i < 12; i++) check($sformatf("silence_bit[%0d]", i), 32'(bits_q[i]), 32'(i % 2));
    check("silence_underrun_cnt", 32'(underrun_cnt), 32'd2);

    // Table of density vectors; osr for the next sample is changed mid-sample.
    do_reset();
    channel = 1'b1;
    osr = 8'(tbl[0].osr);
    push(tbl[0].sample);
    run_events(1, ones);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        osr = 8'(tbl[i+1].osr);
        push(tbl[i+1].sample);
      end
      run_events(tbl[i].osr + 1, ones);
      check($sformatf("tbl_ones[%0d]", i), 32'(ones), 32'(tbl[i].exp_ones));
      if (i == 1) begin
        for (int k = 0; k < 4; k++) check($sformatf("quarter_bit[%0d]", k), 32'(bits_q[k]), (k == 0) ? 32'd0 : 32'd1);
      end
    end

    // Full-scale positive, then zero resumes alternation from the current acc.
    do_reset();
    osr = 8'd255;
    push(32767);
    run_events(1, ones);
    push(0);
    run_events(256, ones);
    check("fullscale_ones", 32'(ones), 32'd256);
    run_events(8, ones);
    for (int i = 0; i < 8; i++) check($sformatf("resume_bit[%0d]", i), 32'(bits_q[i]), 32'(i % 2));

    // Fill with mic_clk stopped, then one pop every osr+1 events.
    do_reset();
    osr = 8'd1;
    @(negedge clk);
    sample_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample_in = 16'((k + 1) * 1000);
      if (k < 4) m_fifo.push_back((k + 1) * 1000);
      @(negedge clk);
      check($sformatf("fill_level[%0d]", k), 32'(fifo_level), (k < 3) ? 32'(k + 1) : 32'd4);
      check($sformatf("fill_ready[%0d]", k), 32'(sample_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    sample_valid = 1'b0;
    run_events(8, ones);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_underrun_cnt", 32'(underrun_cnt), 32'd0);
    run_events(1, ones);
    check("drain_underrun_after", 32'(underrun_cnt), 32'd1);

    // Reset mid-stream with samples queued, then left channel updates on falling edges.
    do_reset();
    osr = 8'd0;
    run_events(4, ones);
    check("pre_reset_pdm", 32'(pdm_out), 32'd1);
    check("pre_reset_cnt", 32'(underrun_cnt), 32'd3);
    push(100); push(200); push(300);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    do_reset();
    channel = 1'b0; osr = 8'd3;
    run_events(8, ones);
    for (int i = 0; i < 8; i++) check($sformatf("left_bit[%0d]", i), 32'(bits_q[i]), 32'(i % 2));
    check("left_underrun_cnt", 32'(underrun_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
